// File: rtl/dpram_be_generic_pkg.sv
// Shared definitions for the byte-enabled dual-port RAM: clear FSM encoding
// and read-during-write mode constants.
package dpram_be_generic_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_t;

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

endpackage

// File: rtl/dpram_be_port_pipe.sv
// Per-port read-data/valid/collision delay line, one or two register stages.
module dpram_be_port_pipe #(
  parameter int width   = 32,
  parameter int out_reg = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             accept,
  input  logic             hit,
  input  logic [width-1:0] rd_data,
  output logic [width-1:0] q,
  output logic             valid,
  output logic             collision
);

  logic [width-1:0] q1;
  logic             v1;
  logic             c1;

  // q only loads on an accepted request, so it holds between valids
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q1 <= '0;
      v1 <= 1'b0;
      c1 <= 1'b0;
    end else begin
      v1 <= accept;
      c1 <= accept & hit;
      if (accept) q1 <= rd_data;
    end
  end

  generate
    if (out_reg != 0) begin : g_out_reg
      logic [width-1:0] q2;
      logic             v2;
      logic             c2;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          q2 <= '0;
          v2 <= 1'b0;
          c2 <= 1'b0;
        end else begin
          v2 <= v1;
          c2 <= c1;
          if (v1) q2 <= q1;
        end
      end

      assign q         = q2;
      assign valid     = v2;
      assign collision = c2;
    end else begin : g_direct
      assign q         = q1;
      assign valid     = v1;
      assign collision = c1;
    end
  endgenerate

endmodule

// File: rtl/dpram_be_generic.sv
// True dual-port RAM with byte enables, selectable read-during-write mode,
// optional output register and a post-reset zero-fill engine.
module dpram_be_generic
  import dpram_be_generic_pkg::*;
#(
  parameter int depth          = 8,
  parameter int width          = 32,
  parameter int rdw_mode       = 0,
  parameter int out_reg        = 0,
  parameter int clear_on_reset = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               busy,
  input  logic               rden_a,
  input  logic               wren_a,
  input  logic [width/8-1:0] byteena_a,
  input  logic [depth-1:0]   address_a,
  input  logic [width-1:0]   data_a,
  output logic [width-1:0]   q_a,
  output logic               valid_a,
  input  logic               rden_b,
  input  logic               wren_b,
  input  logic [width/8-1:0] byteena_b,
  input  logic [depth-1:0]   address_b,
  input  logic [width-1:0]   data_b,
  output logic [width-1:0]   q_b,
  output logic               valid_b,
  output logic               collision,
  output clr_state_t         clear_state
);

  localparam int bytes = width / 8;
  localparam int words = 2 ** depth;
  localparam clr_state_t RESET_STATE = (clear_on_reset != 0) ? ST_CLEAR : ST_READY;
  localparam bit WRITE_FIRST = (rdw_mode == RDW_WRITE_FIRST);

  logic [width-1:0] mem [words];

  clr_state_t       state, state_nxt;
  logic [depth-1:0] clr_addr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RESET_STATE;
      clr_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) clr_addr <= clr_addr + depth'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy = 1'b1;
        if (clr_addr == {depth{1'b1}}) state_nxt = ST_READY;
      end
      ST_READY: state_nxt = ST_READY;
    endcase
  end

  assign clear_state = state;

  // Handshake: a request is taken on any rising edge where rden_x or wren_x
  // is high and busy is low. There is no backpressure; valid_x pulses exactly
  // once per taken request, after the read latency, with q_x alongside.
  logic ready, same_addr;
  logic acc_a, acc_b, wr_a, wr_b, hit;

  assign ready     = (state == ST_READY);
  assign same_addr = (address_a == address_b);
  assign acc_a     = ready & (rden_a | wren_a);
  assign acc_b     = ready & (rden_b | wren_b);
  assign wr_a      = ready & wren_a & (|byteena_a);
  assign wr_b      = ready & wren_b & (|byteena_b);
  assign hit       = acc_a & acc_b & same_addr & (wr_a | wr_b);

  function automatic logic [width-1:0] merge(input logic [width-1:0] old_w,
                                             input logic [width-1:0] data_w,
                                             input logic [bytes-1:0] be);
    merge = old_w;
    for (int i = 0; i < bytes; i++)
      if (be[i]) merge[8*i +: 8] = data_w[8*i +: 8];
  endfunction

  logic [width-1:0] old_a, old_b, fin_a, fin_b, rd_a, rd_b;

  assign old_a = mem[address_a];
  assign old_b = mem[address_b];

  // Final stored word at each port's address; port A is applied last so it
  // wins any lane both ports enable.
  always_comb begin
    fin_a = old_a;
    if (wr_b && same_addr) fin_a = merge(fin_a, data_b, byteena_b);
    if (wr_a)              fin_a = merge(fin_a, data_a, byteena_a);
    fin_b = old_b;
    if (wr_b)              fin_b = merge(fin_b, data_b, byteena_b);
    if (wr_a && same_addr) fin_b = merge(fin_b, data_a, byteena_a);
  end

  assign rd_a = (WRITE_FIRST && wr_a) ? fin_a : old_a;
  assign rd_b = (WRITE_FIRST && wr_b) ? fin_b : old_b;

  always_ff @(posedge clock) begin
    if (state == ST_CLEAR) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int i = 0; i < bytes; i++) begin
        if (wr_b && byteena_b[i]) mem[address_b][8*i +: 8] <= data_b[8*i +: 8];
        if (wr_a && byteena_a[i]) mem[address_a][8*i +: 8] <= data_a[8*i +: 8];
      end
    end
  end

  logic coll_a, coll_b;

  dpram_be_port_pipe #(.width(width), .out_reg(out_reg)) u_pipe_a (
    .clock     (clock),
    .reset_n   (reset_n),
    .accept    (acc_a),
    .hit       (hit),
    .rd_data   (rd_a),
    .q         (q_a),
    .valid     (valid_a),
    .collision (coll_a)
  );

  dpram_be_port_pipe #(.width(width), .out_reg(out_reg)) u_pipe_b (
    .clock     (clock),
    .reset_n   (reset_n),
    .accept    (acc_b),
    .hit       (hit),
    .rd_data   (rd_b),
    .q         (q_b),
    .valid     (valid_b),
    .collision (coll_b)
  );

  assign collision = coll_a | coll_b;

endmodule

// File: tb/tb_dpram_be_generic.sv
// Bench for dpram_be_generic: two instances (write-first/latency 1 and
// read-first/latency 2) share stimulus and are checked against an array model.
module tb_dpram_be_generic;
  import dpram_be_generic_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rden_a, wren_a, rden_b, wren_b;
  logic [3:0]  byteena_a, byteena_b, address_a, address_b;
  logic [31:0] data_a, data_b;

  logic        busy0, valid_a0, valid_b0, collision0;
  logic        busy1, valid_a1, valid_b1, collision1;
  logic [31:0] q_a0, q_b0, q_a1, q_b1;
  clr_state_t  st0, st1;

  dpram_be_generic #(.depth(4), .width(32), .rdw_mode(0), .out_reg(0), .clear_on_reset(1)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .busy(busy0),
    .rden_a(rden_a), .wren_a(wren_a), .byteena_a(byteena_a), .address_a(address_a),
    .data_a(data_a), .q_a(q_a0), .valid_a(valid_a0),
    .rden_b(rden_b), .wren_b(wren_b), .byteena_b(byteena_b), .address_b(address_b),
    .data_b(data_b), .q_b(q_b0), .valid_b(valid_b0),
    .collision(collision0), .clear_state(st0)
  );

  dpram_be_generic #(.depth(4), .width(32), .rdw_mode(1), .out_reg(1), .clear_on_reset(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .busy(busy1),
    .rden_a(rden_a), .wren_a(wren_a), .byteena_a(byteena_a), .address_a(address_a),
    .data_a(data_a), .q_a(q_a1), .valid_a(valid_a1),
    .rden_b(rden_b), .wren_b(wren_b), .byteena_b(byteena_b), .address_b(address_b),
    .data_b(data_b), .q_b(q_b1), .valid_b(valid_b1),
    .collision(collision1), .clear_state(st1)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic        va;
    logic        vb;
    logic        c;
    logic [31:0] qa_wf;
    logic [31:0] qa_rf;
    logic [31:0] qb_wf;
    logic [31:0] qb_rf;
  } res_t;

  res_t        exp_q[$];
  logic [31:0] mdl[16];
  int          clr_left;
  logic [31:0] h0_qa, h0_qb, h1_qa, h1_qb;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic drive(input logic ra, input logic wa, input logic [3:0] ba,
                       input logic [3:0] aa, input logic [31:0] da,
                       input logic rb, input logic wb, input logic [3:0] bb,
                       input logic [3:0] ab, input logic [31:0] db);
    rden_a = ra; wren_a = wa; byteena_a = ba; address_a = aa; data_a = da;
    rden_b = rb; wren_b = wb; byteena_b = bb; address_b = ab; data_b = db;
  endtask

  task automatic idle();
    drive(0, 0, 4'h0, 4'h0, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
  endtask

  // One clock: reference model advance, then scoreboard check of both DUTs.
  task automatic step();
    res_t        r, d;
    logic        ready, acc_a, acc_b, wr_a, wr_b, eb;
    logic [31:0] old_a, old_b;
    ready = (clr_left == 0);
    acc_a = ready && (rden_a || wren_a);
    acc_b = ready && (rden_b || wren_b);
    wr_a  = ready && wren_a && (byteena_a != 4'h0);
    wr_b  = ready && wren_b && (byteena_b != 4'h0);
    old_a = mdl[address_a];
    old_b = mdl[address_b];
    if (!ready) begin
      mdl[16 - clr_left] = 32'h0;
      clr_left--;
    end else begin
      for (int i = 0; i < 4; i++) if (wr_b && byteena_b[i]) mdl[address_b][8*i +: 8] = data_b[8*i +: 8];
      for (int i = 0; i < 4; i++) if (wr_a && byteena_a[i]) mdl[address_a][8*i +: 8] = data_a[8*i +: 8];
    end
    r.va    = acc_a;
    r.vb    = acc_b;
    r.c     = acc_a && acc_b && (address_a == address_b) && (wr_a || wr_b);
    r.qa_wf = wr_a ? mdl[address_a] : old_a;
    r.qa_rf = old_a;
    r.qb_wf = wr_b ? mdl[address_b] : old_b;
    r.qb_rf = old_b;
    @(posedge clock);
    #1;
    exp_q.push_back(r);
    if (exp_q.size() > 2) void'(exp_q.pop_front());
    eb = (clr_left != 0);
    if (r.va) h0_qa = r.qa_wf;
    if (r.vb) h0_qb = r.qb_wf;
    d = '0;
    if (exp_q.size() == 2) d = exp_q[0];
    if (d.va) h1_qa = d.qa_rf;
    if (d.vb) h1_qb = d.qb_rf;

    n_vec++;
    if ({busy0, valid_a0, valid_b0, collision0} !== {eb, r.va, r.vb, r.c}) begin
      n_err++;
      $display("FAIL ctl0 t=%0t busy/va/vb/coll got %b%b%b%b want %b%b%b%b", $time,
               busy0, valid_a0, valid_b0, collision0, eb, r.va, r.vb, r.c);
    end
    n_vec++;
    if ({q_a0, q_b0} !== {h0_qa, h0_qb}) begin
      n_err++;
      $display("FAIL q0 t=%0t q_a/q_b got %h/%h want %h/%h", $time, q_a0, q_b0, h0_qa, h0_qb);
    end
    n_vec++;
    if ({busy1, valid_a1, valid_b1, collision1} !== {eb, d.va, d.vb, d.c}) begin
      n_err++;
      $display("FAIL ctl1 t=%0t busy/va/vb/coll got %b%b%b%b want %b%b%b%b", $time,
               busy1, valid_a1, valid_b1, collision1, eb, d.va, d.vb, d.c);
    end
    n_vec++;
    if ({q_a1, q_b1} !== {h1_qa, h1_qb}) begin
      n_err++;
      $display("FAIL q1 t=%0t q_a/q_b got %h/%h want %h/%h", $time, q_a1, q_b1, h1_qa, h1_qb);
    end
  endtask

  // Asserts reset asynchronously mid-cycle, checks reset values, releases.
  task automatic apply_reset();
    idle();
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    h0_qa = '0; h0_qb = '0; h1_qa = '0; h1_qb = '0;
    clr_left = 16;
    n_vec++;
    if ({busy0, valid_a0, valid_b0, collision0, busy1, valid_a1, valid_b1, collision1} !== 8'b1000_1000) begin
      n_err++;
      $display("FAIL reset_ctl got %b%b%b%b_%b%b%b%b want 1000_1000", busy0, valid_a0, valid_b0,
               collision0, busy1, valid_a1, valid_b1, collision1);
    end
    n_vec++;
    if ({q_a0, q_b0, q_a1, q_b1} !== 128'h0) begin
      n_err++;
      $display("FAIL reset_q got %h %h %h %h want 0", q_a0, q_b0, q_a1, q_b1);
    end
    n_vec++;
    if (st0 !== ST_CLEAR || st1 !== ST_CLEAR) begin
      n_err++;
      $display("FAIL reset_state got %0d/%0d want %0d", st0, st1, ST_CLEAR);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic count_busy(input int already, input string name);
    int cnt;
    cnt = already;
    for (int k = 0; k < 40; k++) begin
      if (!busy0) break;
      step();
      cnt++;
    end
    n_vec++;
    if (cnt !== 16 || busy0 !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy cycles got %0d want 16 (busy now %b)", name, cnt, busy0);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    drive(0, 1, 4'hF, 4'd3, 32'hDEADBEEF, 0, 0, 4'h0, 4'h0, 32'h0);
    step();
    n_vec++;
    if (valid_a0 !== 1'b0) begin
      n_err++;
      $display("FAIL busy_drop valid_a got %b want 0", valid_a0);
    end
    idle();
    count_busy(1, "reset_clear");
    drive(1, 0, 4'h0, 4'd3, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
    step();
    n_vec++;
    if (valid_a0 !== 1'b1 || q_a0 !== 32'h0) begin
      n_err++;
      $display("FAIL clear_read addr3 got v=%b q=%h want v=1 q=00000000", valid_a0, q_a0);
    end
    idle();
    step();
  endtask

  task automatic test_byte_enable();
    drive(0, 1, 4'b1111, 4'd5, 32'h11223344, 0, 0, 4'h0, 4'h0, 32'h0);
    step();
    drive(0, 1, 4'b0101, 4'd5, 32'hAABBCCDD, 0, 0, 4'h0, 4'h0, 32'h0);
    step();
    drive(1, 0, 4'h0, 4'd5, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
    step();
    n_vec++;
    if (q_a0 !== 32'h11BB33DD) begin
      n_err++;
      $display("FAIL byte_enable q_a got %h want 11bb33dd", q_a0);
    end
    idle();
    step();
  endtask

  task automatic test_ww_collision();
    drive(0, 1, 4'b0011, 4'd7, 32'hAAAAAAAA, 0, 1, 4'b1111, 4'd7, 32'hBBBBBBBB);
    step();
    n_vec++;
    if (collision0 !== 1'b1) begin
      n_err++;
      $display("FAIL ww_collision pulse got %b want 1", collision0);
    end
    idle();
    step();
    n_vec++;
    if (collision0 !== 1'b0 || collision1 !== 1'b1) begin
      n_err++;
      $display("FAIL ww_collision width got c0=%b c1=%b want 0/1", collision0, collision1);
    end
    drive(1, 0, 4'h0, 4'd7, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
    step();
    n_vec++;
    if (q_a0 !== 32'hBBBBAAAA) begin
      n_err++;
      $display("FAIL ww_result mem7 got %h want bbbbaaaa", q_a0);
    end
    idle();
    step();
  endtask

  task automatic test_cross_port();
    drive(0, 1, 4'hF, 4'd2, 32'h1, 0, 0, 4'h0, 4'h0, 32'h0);
    step();
    drive(0, 1, 4'hF, 4'd2, 32'h2, 1, 0, 4'h0, 4'd2, 32'h0);
    step();
    n_vec++;
    if (q_a0 !== 32'h2 || q_b0 !== 32'h1 || collision0 !== 1'b1) begin
      n_err++;
      $display("FAIL cross_wf got qa=%h qb=%h c=%b want 2/1/1", q_a0, q_b0, collision0);
    end
    idle();
    step();
    n_vec++;
    if (q_a1 !== 32'h1 || q_b1 !== 32'h1 || collision1 !== 1'b1) begin
      n_err++;
      $display("FAIL cross_rf got qa=%h qb=%h c=%b want 1/1/1", q_a1, q_b1, collision1);
    end
    step();
  endtask

  task automatic test_latency();
    drive(1, 0, 4'h0, 4'd9, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
    step();
    n_vec++;
    if (valid_a0 !== 1'b1 || valid_a1 !== 1'b0) begin
      n_err++;
      $display("FAIL latency_n1 got v0=%b v1=%b want 1/0", valid_a0, valid_a1);
    end
    idle();
    step();
    n_vec++;
    if (valid_a0 !== 1'b0 || valid_a1 !== 1'b1) begin
      n_err++;
      $display("FAIL latency_n2 got v0=%b v1=%b want 0/1", valid_a0, valid_a1);
    end
    step();
    n_vec++;
    if (valid_a1 !== 1'b0) begin
      n_err++;
      $display("FAIL latency_n3 got v1=%b want 0", valid_a1);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 4'hF, 4'(i), $urandom, 1, 0, 4'h0, 4'(15 - i), 32'h0);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 4'h0, 4'(i), 32'h0, 1, 0, 4'h0, 4'(i), 32'h0);
      step();
      n_vec++;
      if (valid_a0 !== 1'b1 || valid_b0 !== 1'b1 || (i > 0 && valid_a1 !== 1'b1)) begin
        n_err++;
        $display("FAIL back_to_back i=%0d got v0=%b%b v1=%b", i, valid_a0, valid_b0, valid_a1);
      end
    end
    idle();
    step();
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 3)), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 3)), $urandom);
      step();
    end
    idle();
    step();
    step();
  endtask

  task automatic test_reset_mid_clear();
    apply_reset();
    for (int i = 0; i < 8; i++) step();
    apply_reset();
    count_busy(0, "mid_clear");
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 4'h0, 4'(i), 32'h0, 1, 0, 4'h0, 4'(15 - i), 32'h0);
      step();
      n_vec++;
      if (q_a0 !== 32'h0 || q_b0 !== 32'h0) begin
        n_err++;
        $display("FAIL mid_clear_read addr=%0d got %h/%h want 0", i, q_a0, q_b0);
      end
    end
    idle();
    step();
    step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    idle();
    test_reset();
    test_byte_enable();
    test_ww_collision();
    test_cross_port();
    test_latency();
    test_back_to_back();
    test_random();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
